// File: rtl/alu_issue_unit.sv
// Sequential front end for the 32-bit combinational ALU: decodes the ALU control code,
// holds the ALU inputs stable for a settle window, then hands the result downstream.
module alu_issue_unit #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic        alu_src,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_illegal
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  localparam logic [3:0] CODE_AND     = 4'b0000;
  localparam logic [3:0] CODE_OR      = 4'b0110;
  localparam logic [3:0] CODE_ADD     = 4'b0010;
  localparam logic [3:0] CODE_SUB     = 4'b0001;
  localparam logic [3:0] CODE_SLT     = 4'b0111;
  localparam logic [3:0] CODE_NOR     = 4'b1100;
  localparam logic [3:0] CODE_SLL     = 4'b0100;
  localparam logic [3:0] CODE_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] count;
  logic       illegal_q;
  logic [3:0] dec_control;
  logic       dec_illegal;

  always_comb begin
    // NOTE: default every output first so no path through the case leaves one unassigned (no latch).
    dec_control = CODE_ADD;
    dec_illegal = 1'b0;
    unique case (alu_op)
      2'b00: dec_control = CODE_ADD;
      2'b01: dec_control = CODE_SUB;
      2'b11: dec_control = CODE_OR;
      2'b10: begin
        unique case (funct)
          6'b100100: dec_control = CODE_AND;
          6'b100101: dec_control = CODE_OR;
          6'b100000: dec_control = CODE_ADD;
          6'b100010: dec_control = CODE_SUB;
          6'b101010: dec_control = CODE_SLT;
          6'b100111: dec_control = CODE_NOR;
          6'b000000: dec_control = CODE_SLL;
          default: begin
            dec_control = CODE_ILLEGAL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_control = CODE_ADD;
    endcase
  end

  // Handshake flags decode from state only, so reset drops out_valid without a clock edge.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      illegal_q   <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shamt   <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            alu_control <= dec_control;
            alu_a       <= rs_data;
            alu_b       <= alu_src ? imm : rt_data;
            alu_shamt   <= shamt_in;
            illegal_q   <= dec_illegal;
            count       <= CNT_INIT;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (count == 4'd0) begin
            out_result  <= alu_result;
            out_zero    <= alu_zero;
            out_illegal <= illegal_q;
            state       <= HOLD;
          end else begin
            count <= count - 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: a behavioural ALU closes the loop, and a second
// instance with a one-cycle settle window runs alongside the default one.
module tb_alu_issue_unit;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt_in;
  logic [31:0] rs_data, rt_data, imm;
  logic        alu_src;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, out_illegal;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, out_result, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  logic        in_ready1, out_valid1, out_zero1, out_illegal1;
  logic [3:0]  alu_control1;
  logic [31:0] alu_a1, alu_b1, out_result1, alu_result1;
  logic [4:0]  alu_shamt1;
  logic        alu_zero1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (c)
      4'b0000: return a & b;
      4'b0110: return a | b;
      4'b0010: return a + b;
      4'b0001: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b0100: return a << sh;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result  = alu_model(alu_control, alu_a, alu_b, alu_shamt);
  assign alu_zero    = (alu_result == 32'd0);
  assign alu_result1 = alu_model(alu_control1, alu_a1, alu_b1, alu_shamt1);
  assign alu_zero1   = (alu_result1 == 32'd0);

  alu_issue_unit #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt_in(shamt_in), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .alu_src(alu_src), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_result(alu_result),
    .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  alu_issue_unit #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_op(alu_op), .funct(funct), .shamt_in(shamt_in), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .alu_src(alu_src), .alu_control(alu_control1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_shamt(alu_shamt1), .alu_result(alu_result1),
    .alu_zero(alu_zero1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(out_result1), .out_zero(out_zero1), .out_illegal(out_illegal1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one op, checks the ALU-side registers after accept and the capture timing;
  // leaves both units in HOLD with out_ready low.
  task automatic issue(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] im, input logic src, input logic [3:0] exp_ctrl,
                       input logic [31:0] exp_b, input logic [31:0] exp_res,
                       input logic exp_zero, input logic exp_ill);
    check({name, ".in_ready_before"}, {31'd0, in_ready}, 32'd1);
    alu_op = op; funct = fn; shamt_in = sh; rs_data = rs; rt_data = rt;
    imm = im; alu_src = src; in_valid = 1'b1;
    tick();                                   // accept edge k
    in_valid = 1'b0;
    check({name, ".in_ready_after"}, {31'd0, in_ready}, 32'd0);
    check({name, ".alu_control"}, {28'd0, alu_control}, {28'd0, exp_ctrl});
    check({name, ".alu_a"}, alu_a, rs);
    check({name, ".alu_b"}, alu_b, exp_b);
    check({name, ".alu_shamt"}, {27'd0, alu_shamt}, {27'd0, sh});
    tick();                                   // edge k+1
    check({name, ".s1_valid"}, {31'd0, out_valid1}, 32'd1);
    check({name, ".s1_result"}, out_result1, exp_res);
    repeat (S - 2) tick();                    // edge k+S-1
    check({name, ".valid_early"}, {31'd0, out_valid}, 32'd0);
    tick();                                   // edge k+S
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".result"}, out_result, exp_res);
    check({name, ".zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    check({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, ".s1_idle_valid"}, {31'd0, out_valid1}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; funct = '0;
    shamt_in = '0; rs_data = '0; rt_data = '0; imm = '0; alu_src = 1'b0;
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.alu_control", {28'd0, alu_control}, 32'd0);
    check("rst.out_result", out_result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue("add", 2'b10, 6'b100000, 5'd0, 32'd5, 32'd7, 32'd99, 1'b0,
          4'b0010, 32'd7, 32'd12, 1'b0, 1'b0);
    release_out("add");
    check("idle.keeps_alu_b", alu_b, 32'd7);
    issue("beq", 2'b01, 6'b100101, 5'd0, 32'h1234, 32'h1234, 32'd0, 1'b0,
          4'b0001, 32'h1234, 32'd0, 1'b1, 1'b0);
    release_out("beq");
    issue("lw", 2'b00, 6'b111111, 5'd0, 32'd16, 32'd1, 32'hFFFF_FFFC, 1'b1,
          4'b0010, 32'hFFFF_FFFC, 32'd12, 1'b0, 1'b0);
    release_out("lw");
    issue("sll", 2'b10, 6'b000000, 5'd3, 32'd1, 32'd1, 32'd0, 1'b0,
          4'b0100, 32'd1, 32'd8, 1'b0, 1'b0);
    release_out("sll");
    issue("ori", 2'b11, 6'b000000, 5'd0, 32'hF0, 32'd0, 32'h0F, 1'b1,
          4'b0110, 32'h0F, 32'hFF, 1'b0, 1'b0);
    release_out("ori");
    issue("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0,
          4'b0111, 32'd1, 32'd1, 1'b0, 1'b0);
    release_out("slt");
    issue("nor", 2'b10, 6'b100111, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
          4'b1100, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    release_out("nor");
    issue("and", 2'b10, 6'b100100, 5'd0, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0,
          4'b0000, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
    release_out("and");
    issue("illegal", 2'b10, 6'b111111, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0,
          4'b1111, 32'd4, 32'd0, 1'b1, 1'b1);
    release_out("illegal");

    // Backpressure: hold in HOLD for five cycles with a competing request.
    issue("bp", 2'b10, 6'b100010, 5'd0, 32'd10, 32'd3, 32'd0, 1'b0,
          4'b0001, 32'd3, 32'd7, 1'b0, 1'b0);
    alu_op = 2'b00; rs_data = 32'd55; rt_data = 32'd66; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.valid", {31'd0, out_valid}, 32'd1);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.result", out_result, 32'd7);
      check("bp.alu_a", alu_a, 32'd10);
    end
    in_valid = 1'b0;
    release_out("bp");
    check("bp.no_accept", alu_a, 32'd10);

    // Reset two cycles into SETTLE (the one-cycle unit is in HOLD by then).
    issue_partial();
    reset = 1'b1;
    #1;
    check("abort.out_valid", {31'd0, out_valid}, 32'd0);
    check("abort.s1_valid", {31'd0, out_valid1}, 32'd0);
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.alu_control", {28'd0, alu_control}, 32'd0);
    check("abort.alu_a", alu_a, 32'd0);
    check("abort.alu_b", alu_b, 32'd0);
    check("abort.out_result", out_result1, 32'd0);
    check("abort.out_zero", {31'd0, out_zero1}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (S + 1) tick();
    check("abort.no_result", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic issue_partial();
    alu_op = 2'b10; funct = 6'b100000; rs_data = 32'd9; rt_data = 32'd9;
    alu_src = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("abort.pre_settle", {31'd0, out_valid}, 32'd0);
  endtask

endmodule
